// File: rtl/sbox_engine.sv
// sbox_engine: multi-cycle AES SubBytes/InvSubBytes engine processing LANES bytes per cycle behind a valid/ready handshake
module sbox_engine #(
    parameter int NBYTES = 16,
    parameter int LANES  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [8*NBYTES-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_data,
    output logic                busy
);
    localparam int BEATS = NBYTES / LANES;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [8*NBYTES-1:0] src_q, src_d, res_q, res_d;
    logic                mode_q, mode_d;
    logic                out_valid_q, out_valid_d, busy_q, busy_d;
    logic                acc;

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ t : p;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] sq, acc_v;
        sq = x;
        acc_v = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            acc_v = gmul(acc_v, sq);
        end
        return acc_v;
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        logic [7:0] x, y;
        x = inv ? rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05 : b;
        y = ginv(x);
        return inv ? y : y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    endfunction

    assign acc = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            src_q       <= '0;
            res_q       <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            res_q       <= res_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = acc ? RUN : IDLE;
            RUN:     state_d = (cnt_q == CW'(BEATS - 1)) ? DONE : RUN;
            DONE:    state_d = out_ready ? (in_valid ? RUN : IDLE) : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        src_d  = src_q;
        mode_d = mode_q;
        res_d  = res_q;
        if (acc) begin
            cnt_d  = '0;
            src_d  = in_data;
            mode_d = in_mode;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (state_q == RUN)
            for (int l = 0; l < LANES; l++)
                res_d[8*(int'(cnt_q)*LANES+l) +: 8] = sub_byte(src_q[8*(int'(cnt_q)*LANES+l) +: 8], mode_q);
        out_valid_d = state_d == DONE;
        busy_d      = state_d != IDLE;
    end

    always_comb begin
        in_ready  = !rst && (state_q == IDLE || (state_q == DONE && out_ready));
        out_valid = out_valid_q;
        busy      = busy_q;
        out_data  = res_q;
    end
endmodule

// File: tb/tb_sbox_engine.sv
// tb_sbox_engine: table-driven reference model checks four LANES configurations under directed and random traffic
module tb_sbox_engine;
    localparam logic [127:0] VEC = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] RES = 128'h1628c14beaaceec4f533fc1bc3938263;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    bit done [4];
    logic [0:255][7:0] fwd;
    logic [7:0] inv [256];

    function automatic void chk(input int lanes, input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL L%0d %s: got %h expected %h", lanes, name, act, exp);
        end
    endfunction

    function automatic logic [127:0] sub_word(input logic [127:0] w, input logic m);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = m ? inv[w[8*i +: 8]] : fwd[w[8*i +: 8]];
        return r;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : inst
        localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 16;
        localparam int LAT = (g == 0) ? 4 : (g == 1) ? 16 : (g == 2) ? 8 : 1;

        logic rst, in_valid, in_mode, out_ready, in_ready, out_valid, busy;
        logic [127:0] in_data, out_data;
        int left = -1;
        logic [127:0] exp_word = '0;
        logic exp_ov, exp_rdy;

        sbox_engine #(.NBYTES(16), .LANES(L)) dut (
            .clk(clk),
            .rst(rst),
            .in_valid(in_valid),
            .in_ready(in_ready),
            .in_mode(in_mode),
            .in_data(in_data),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .out_data(out_data),
            .busy(busy)
        );

        // left = cycles until the pending result is due; -1 when no transaction is open
        always @(negedge clk) begin
            if (rst) begin
                chk(L, "rst_in_ready", in_ready, 0);
                chk(L, "rst_out_valid", out_valid, 0);
                chk(L, "rst_busy", busy, 0);
                chk(L, "rst_out_data", out_data, 0);
                left = -1;
            end else begin
                exp_ov = (left == 0);
                exp_rdy = (left < 0) || (exp_ov && out_ready);
                chk(L, "out_valid", out_valid, exp_ov);
                chk(L, "busy", busy, left >= 0);
                chk(L, "in_ready", in_ready, exp_rdy);
                if (exp_ov) chk(L, "out_data", out_data, exp_word);
                if (exp_ov && out_ready) left = -1;
                else if (left > 0) left--;
                if (in_valid && exp_rdy) begin
                    left = LAT;
                    exp_word = sub_word(in_data, in_mode);
                end
            end
        end

        task automatic send(input logic [127:0] d, input logic m);
            int n;
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_data = d;
            in_mode = m;
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) chk(L, "send_timeout", n, 0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        endtask

        task automatic measure(output int lat);
            lat = 0;
            @(negedge clk);
            while (!out_valid && lat < 100) begin
                @(negedge clk);
                lat++;
            end
        endtask

        task automatic run_vec(input logic [127:0] d, input logic m, input logic [127:0] e, input string nm);
            int lat;
            out_ready = 1'b1;
            send(d, m);
            measure(lat);
            chk(L, {nm, "_lat"}, lat, LAT);
            chk(L, nm, out_data, e);
            @(negedge clk);
            chk(L, {nm, "_ov_drop"}, out_valid, 0);
        endtask

        initial begin
            int lat;
            logic [127:0] held, a;
            rst = 1'b1;
            in_valid = 1'b0;
            in_mode = 1'b0;
            in_data = '0;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;
            #1;
            chk(L, "ready_after_rst", in_ready, 1);
            run_vec(VEC, 1'b0, RES, "fwd_vec");
            run_vec(RES, 1'b1, VEC, "inv_vec");
            out_ready = 1'b1;
            for (int v = 0; v < 256; v++)
                for (int m = 0; m < 2; m++)
                    send({16{8'(v)}}, m[0]);
            repeat (LAT + 3) @(posedge clk);
            out_ready = 1'b0;
            a = {$urandom, $urandom, $urandom, $urandom};
            send(a, 1'b0);
            measure(lat);
            chk(L, "bp_lat", lat, LAT);
            held = out_data;
            in_valid = 1'b1;
            in_mode = 1'b1;
            in_data = {$urandom, $urandom, $urandom, $urandom};
            repeat (5) begin
                @(negedge clk);
                chk(L, "bp_stable", out_data, held);
                chk(L, "bp_in_ready", in_ready, 0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            in_data = VEC;
            in_mode = 1'b0;
            @(negedge clk);
            chk(L, "b2b_ready", in_ready, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            measure(lat);
            chk(L, "b2b_lat", lat, LAT);
            chk(L, "b2b_data", out_data, RES);
            repeat (1500) begin
                @(posedge clk);
                #1;
                in_valid = 1'($urandom_range(0, 1));
                in_mode = 1'($urandom_range(0, 1));
                in_data = {$urandom, $urandom, $urandom, $urandom};
                out_ready = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            out_ready = 1'b1;
            repeat (LAT + 3) @(posedge clk);
            send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
            @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            chk(L, "abort_out_valid", out_valid, 0);
            chk(L, "abort_busy", busy, 0);
            chk(L, "abort_out_data", out_data, 0);
            chk(L, "abort_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            #1;
            chk(L, "abort_ready_after", in_ready, 1);
            run_vec(VEC, 1'b0, RES, "post_rst");
            done[g] = 1'b1;
        end
    end

    initial begin
        int t;
        fwd = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
               128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
               128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
               128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
               128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
               128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
               128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
               128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) inv[fwd[i]] = 8'(i);
        chk(0, "pin_fwd_53", fwd[8'h53], 8'hed);
        chk(0, "pin_fwd_00", fwd[8'h00], 8'h63);
        chk(0, "pin_inv_00", inv[8'h00], 8'h52);
        chk(0, "pin_vec", sub_word(VEC, 1'b0), RES);
        t = 0;
        while (!(done[0] && done[1] && done[2] && done[3]) && t < 90000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 90000) chk(0, "global_timeout", t, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
